// File: rtl/rab_axi_pkg.sv
// Shared definitions for the RAB AXI4 read-data return path.
//  - R-beat field offsets for the packed {ruser, rdata, rid, rlast, rresp} word
//  - helper functions giving the data/user offsets and the total beat width
//  - store-and-forward FSM state type
package rab_axi_pkg;

    localparam int unsigned RESP_LSB = 0;
    localparam int unsigned LAST_BIT = 2;
    localparam int unsigned ID_LSB   = 3;

    function automatic int unsigned data_lsb(input int unsigned id_w);
        return ID_LSB + id_w;
    endfunction

    function automatic int unsigned user_lsb(input int unsigned id_w, input int unsigned data_w);
        return ID_LSB + id_w + data_w;
    endfunction

    function automatic int unsigned r_beat_width(input int unsigned id_w,
                                                 input int unsigned data_w,
                                                 input int unsigned user_w);
        return ID_LSB + id_w + data_w + user_w;
    endfunction

    typedef enum logic {Hold, Cut} sf_state_e;

endpackage

// File: rtl/rab_sync_fifo.sv
// Generic synchronous FIFO, DATA_WIDTH x DEPTH (DEPTH a power of two).
// Ports:
//  clk, rst        clock, synchronous active-high reset (pointers/level only)
//  push, wdata     write request; ignored when full
//  pop             read request; ignored when empty
//  rdata           head entry (valid when !empty)
//  level           entries held, full, empty
module rab_sync_fifo #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic                    pop,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    full,
    output logic                    empty
);

    localparam int unsigned PtrW = $clog2(DEPTH);

    logic [PtrW-1:0]       wptr_q, rptr_q;
    logic [PtrW:0]         level_q;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic                  do_push, do_pop;

    assign full    = (level_q == (PtrW+1)'(DEPTH));
    assign empty   = (level_q == '0);
    // A pop at full does not make room for a same-cycle push.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rptr_q];
    assign level   = level_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + PtrW'(1);
            if (do_pop)  rptr_q <= rptr_q + PtrW'(1);
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + (PtrW+1)'(1);
                2'b01:   level_q <= level_q - (PtrW+1)'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= wdata;
    end

endmodule

// File: rtl/axi4_r_buffer_fifo.sv
// AXI4 R-channel elastic buffer for the RAB read-data return path.
// Accepts beats on m_axi4_* and returns them in order on s_axi4_*.
// With STORE_FWD=1 a burst is held until its RLAST beat is buffered; if the
// buffer fills without any RLAST inside, it falls back to cut-through until
// the burst's last beat leaves, so long bursts cannot deadlock.
// Ports:
//  axi4_aclk, axi4_arst          clock, synchronous active-high reset
//  m_axi4_r*  (in), m_axi4_rready (out)   upstream R channel
//  s_axi4_r*  (out), s_axi4_rready (in)   downstream R channel, payload zero when idle
//  level, almost_full, bursts_pending     fill status for flow control
//  sf_overflow                            1-cycle pulse on entering cut-through fallback
module axi4_r_buffer_fifo
    import rab_axi_pkg::*;
#(
    parameter int unsigned AXI_DATA_WIDTH = 32,
    parameter int unsigned AXI_ID_WIDTH   = 4,
    parameter int unsigned AXI_USER_WIDTH = 4,
    parameter int unsigned DEPTH          = 4,
    parameter int unsigned STORE_FWD      = 0,
    parameter int unsigned AFULL_THRESH   = 3
) (
    input  logic                        axi4_aclk,
    input  logic                        axi4_arst,
    input  logic [AXI_ID_WIDTH-1:0]     m_axi4_rid,
    input  logic [AXI_DATA_WIDTH-1:0]   m_axi4_rdata,
    input  logic [1:0]                  m_axi4_rresp,
    input  logic                        m_axi4_rlast,
    input  logic [AXI_USER_WIDTH-1:0]   m_axi4_ruser,
    input  logic                        m_axi4_rvalid,
    output logic                        m_axi4_rready,
    output logic [AXI_ID_WIDTH-1:0]     s_axi4_rid,
    output logic [AXI_DATA_WIDTH-1:0]   s_axi4_rdata,
    output logic [1:0]                  s_axi4_rresp,
    output logic                        s_axi4_rlast,
    output logic [AXI_USER_WIDTH-1:0]   s_axi4_ruser,
    output logic                        s_axi4_rvalid,
    input  logic                        s_axi4_rready,
    output logic [$clog2(DEPTH):0]      level,
    output logic                        almost_full,
    output logic [$clog2(DEPTH):0]      bursts_pending,
    output logic                        sf_overflow
);

    localparam int unsigned LvlW   = $clog2(DEPTH) + 1;
    localparam int unsigned BeatW  = r_beat_width(AXI_ID_WIDTH, AXI_DATA_WIDTH, AXI_USER_WIDTH);
    localparam int unsigned DataLsb = data_lsb(AXI_ID_WIDTH);
    localparam int unsigned UserLsb = user_lsb(AXI_ID_WIDTH, AXI_DATA_WIDTH);

    logic [BeatW-1:0] wbeat, head;
    logic [LvlW-1:0]  fifo_level, bursts_q, bursts_d;
    logic             push, pop, full, empty, head_last, push_last, pop_last;
    logic             head_valid, overflow, s_valid;
    sf_state_e        state_q, state_d;

    assign wbeat = {m_axi4_ruser, m_axi4_rdata, m_axi4_rid, m_axi4_rlast, m_axi4_rresp};

    assign m_axi4_rready = !full && !axi4_arst;
    assign push          = m_axi4_rvalid && m_axi4_rready;
    assign pop           = s_valid && s_axi4_rready;
    assign head_last     = head[LAST_BIT];
    assign push_last     = push && m_axi4_rlast;
    assign pop_last      = pop && head_last;

    rab_sync_fifo #(
        .DATA_WIDTH (BeatW),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk   (axi4_aclk),
        .rst   (axi4_arst),
        .push  (push),
        .wdata (wbeat),
        .pop   (pop),
        .rdata (head),
        .level (fifo_level),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        bursts_d = bursts_q;
        if (push_last && !pop_last) begin
            bursts_d = bursts_q + LvlW'(1);
        end else if (!push_last && pop_last) begin
            bursts_d = bursts_q - LvlW'(1);
        end
    end

    always_comb begin
        state_d    = state_q;
        overflow   = 1'b0;
        head_valid = !empty;
        if (STORE_FWD != 0) begin
            unique case (state_q)
                Hold: begin
                    // Full with no complete burst inside: release the head now
                    // (same cycle) so the stalled burst can drain.
                    overflow   = full && (bursts_q == '0);
                    head_valid = !empty && ((bursts_q != '0) || overflow);
                    if (overflow) state_d = Cut;
                end
                Cut: begin
                    if (pop_last) state_d = Hold;
                end
                default: state_d = Hold;
            endcase
        end
    end

    always_ff @(posedge axi4_aclk) begin
        if (axi4_arst) begin
            bursts_q <= '0;
            state_q  <= Hold;
        end else begin
            bursts_q <= bursts_d;
            state_q  <= state_d;
        end
    end

    assign s_valid        = head_valid && !axi4_arst;
    assign s_axi4_rvalid  = s_valid;
    assign s_axi4_rresp   = s_valid ? head[RESP_LSB +: 2] : '0;
    assign s_axi4_rlast   = s_valid && head_last;
    assign s_axi4_rid     = s_valid ? head[ID_LSB +: AXI_ID_WIDTH] : '0;
    assign s_axi4_rdata   = s_valid ? head[DataLsb +: AXI_DATA_WIDTH] : '0;
    assign s_axi4_ruser   = s_valid ? head[UserLsb +: AXI_USER_WIDTH] : '0;

    assign level          = axi4_arst ? '0 : fifo_level;
    assign almost_full    = !axi4_arst && (fifo_level >= LvlW'(AFULL_THRESH));
    assign bursts_pending = axi4_arst ? '0 : bursts_q;
    assign sf_overflow    = overflow && !axi4_arst;

endmodule

// File: tb/tb_axi4_r_buffer_fifo.sv
module tb_axi4_r_buffer_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel;  // 0: cut-through instance, 1: store-and-forward instance
    logic [3:0]  m_id;
    logic [31:0] m_data;
    logic [1:0]  m_resp;
    logic        m_last;
    logic [3:0]  m_user;
    logic        m_valid;
    logic        s_ready;

    logic        c_mready, c_svalid, c_last, c_af, c_ovf;
    logic [3:0]  c_id, c_user;
    logic [31:0] c_data;
    logic [1:0]  c_resp;
    logic [2:0]  c_level, c_bursts;
    logic        f_mready, f_svalid, f_last, f_af, f_ovf;
    logic [3:0]  f_id, f_user;
    logic [31:0] f_data;
    logic [1:0]  f_resp;
    logic [2:0]  f_level, f_bursts;

    always #5 clk = ~clk;

    axi4_r_buffer_fifo #(
        .AXI_DATA_WIDTH (32), .AXI_ID_WIDTH (4), .AXI_USER_WIDTH (4),
        .DEPTH (4), .STORE_FWD (0), .AFULL_THRESH (3)
    ) dut_ct (
        .axi4_aclk (clk), .axi4_arst (rst),
        .m_axi4_rid (m_id), .m_axi4_rdata (m_data), .m_axi4_rresp (m_resp),
        .m_axi4_rlast (m_last), .m_axi4_ruser (m_user),
        .m_axi4_rvalid (m_valid && !sel), .m_axi4_rready (c_mready),
        .s_axi4_rid (c_id), .s_axi4_rdata (c_data), .s_axi4_rresp (c_resp),
        .s_axi4_rlast (c_last), .s_axi4_ruser (c_user), .s_axi4_rvalid (c_svalid),
        .s_axi4_rready (s_ready && !sel),
        .level (c_level), .almost_full (c_af), .bursts_pending (c_bursts),
        .sf_overflow (c_ovf)
    );

    axi4_r_buffer_fifo #(
        .AXI_DATA_WIDTH (32), .AXI_ID_WIDTH (4), .AXI_USER_WIDTH (4),
        .DEPTH (4), .STORE_FWD (1), .AFULL_THRESH (3)
    ) dut_sf (
        .axi4_aclk (clk), .axi4_arst (rst),
        .m_axi4_rid (m_id), .m_axi4_rdata (m_data), .m_axi4_rresp (m_resp),
        .m_axi4_rlast (m_last), .m_axi4_ruser (m_user),
        .m_axi4_rvalid (m_valid && sel), .m_axi4_rready (f_mready),
        .s_axi4_rid (f_id), .s_axi4_rdata (f_data), .s_axi4_rresp (f_resp),
        .s_axi4_rlast (f_last), .s_axi4_ruser (f_user), .s_axi4_rvalid (f_svalid),
        .s_axi4_rready (s_ready && sel),
        .level (f_level), .almost_full (f_af), .bursts_pending (f_bursts),
        .sf_overflow (f_ovf)
    );

    // Observed view of the selected instance.
    logic        o_mready, o_svalid, o_last, o_af, o_ovf;
    logic [3:0]  o_id, o_user;
    logic [31:0] o_data;
    logic [1:0]  o_resp;
    logic [2:0]  o_level, o_bursts;
    logic [42:0] o_beat, in_beat;

    assign o_mready = sel ? f_mready : c_mready;
    assign o_svalid = sel ? f_svalid : c_svalid;
    assign o_last   = sel ? f_last   : c_last;
    assign o_af     = sel ? f_af     : c_af;
    assign o_ovf    = sel ? f_ovf    : c_ovf;
    assign o_id     = sel ? f_id     : c_id;
    assign o_user   = sel ? f_user   : c_user;
    assign o_data   = sel ? f_data   : c_data;
    assign o_resp   = sel ? f_resp   : c_resp;
    assign o_level  = sel ? f_level  : c_level;
    assign o_bursts = sel ? f_bursts : c_bursts;
    assign o_beat   = {o_user, o_data, o_id, o_last, o_resp};
    assign in_beat  = {m_user, m_data, m_id, m_last, m_resp};

    int n_chk = 0;
    int n_err = 0;
    int delivered = 0;
    int ovf_cnt = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard and protocol monitor, sampled at the falling edge.
    logic [42:0] sb_q[$];
    initial begin : monitor
        logic        pend;
        logic [42:0] pend_beat;
        logic [42:0] exp_beat;
        pend = 1'b0;
        pend_beat = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                sb_q.delete();
                pend = 1'b0;
            end else begin
                if (pend) begin
                    check("hold_valid", 64'(o_svalid), 64'd1);
                    check("hold_payload", 64'(o_beat), 64'(pend_beat));
                end
                if (o_svalid && s_ready) begin
                    check("sb_nonempty", 64'(sb_q.size() != 0), 64'd1);
                    if (sb_q.size() != 0) begin
                        exp_beat = sb_q.pop_front();
                        check("sb_beat", 64'(o_beat), 64'(exp_beat));
                    end
                    delivered++;
                end
                if (m_valid && o_mready) sb_q.push_back(in_beat);
                if (m_valid && o_level == 3'd4) check("no_push_full", 64'(o_mready), 64'd0);
                if (o_ovf) ovf_cnt++;
                pend      = o_svalid && !s_ready;
                pend_beat = o_beat;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_beat(input logic [3:0] id, input logic [31:0] data, input logic [3:0] user,
                            input logic last, input logic [1:0] resp);
        m_id = id; m_data = data; m_user = user; m_last = last; m_resp = resp;
        m_valid = 1'b1;
    endtask

    // Present the current beat until accepted (bounded), then drop valid.
    task automatic send(input logic [3:0] id, input logic [31:0] data, input logic [3:0] user,
                        input logic last, input logic [1:0] resp);
        logic h;
        h = 1'b0;
        set_beat(id, data, user, last, resp);
        for (int i = 0; i < 200 && !h; i++) begin
            @(negedge clk);
            h = o_mready;
            cyc();
        end
        check("send_accept", 64'(h), 64'd1);
        m_valid = 1'b0;
    endtask

    task automatic drain();
        logic done;
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            done = (o_level == 3'd0) && !o_svalid;
            if (!done) cyc();
        end
        check("drain_empty", 64'(done), 64'd1);
        cyc();
    endtask

    task automatic do_reset(input logic which);
        rst = 1'b1;
        m_valid = 1'b0;
        s_ready = 1'b0;
        sel = which;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic random_run(input int n);
        delivered = 0;
        fork
            begin
                for (int i = 0; i < n; i++) begin
                    int idle;
                    idle = $urandom_range(0, 2);
                    for (int j = 0; j < idle; j++) cyc();
                    send(4'($urandom_range(0, 15)), $urandom, 4'($urandom_range(0, 15)),
                         (i == n - 1) || ($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)));
                end
            end
            begin
                for (int c = 0; c < n * 20 && delivered < n; c++) begin
                    s_ready = 1'($urandom_range(0, 1));
                    cyc();
                end
            end
        join
        s_ready = 1'b1;
        drain();
        check("rand_count", 64'(delivered), 64'(n));
        s_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; sel = 1'b0; m_valid = 1'b0; s_ready = 1'b0;
        m_id = '0; m_data = '0; m_user = '0; m_last = 1'b0; m_resp = '0;
        cyc();
        cyc();

        // 1: reset state, then reset asserted mid-traffic.
        @(negedge clk);
        check("rst_rready", 64'(o_mready), 64'd0);
        check("rst_level0", 64'(o_level), 64'd0);
        cyc();
        rst = 1'b0;
        @(negedge clk);
        check("rel_rready", 64'(o_mready), 64'd1);
        cyc();
        send(4'h1, 32'h1111_0000, 4'h1, 1'b0, 2'b00);
        send(4'h1, 32'h1111_0001, 4'h1, 1'b1, 2'b01);
        set_beat(4'h1, 32'h1111_0002, 4'h1, 1'b0, 2'b00);
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("rst_level", 64'(o_level), 64'd0);
            check("rst_svalid", 64'(o_svalid), 64'd0);
            check("rst_rready", 64'(o_mready), 64'd0);
            check("rst_payload", 64'(o_beat), 64'd0);
            check("rst_bursts", 64'(o_bursts), 64'd0);
            check("rst_afull", 64'(o_af), 64'd0);
            cyc();
        end
        rst = 1'b0;
        m_valid = 1'b0;
        @(negedge clk);
        check("rel2_rready", 64'(o_mready), 64'd1);
        check("rel2_level", 64'(o_level), 64'd0);
        cyc();

        // 2: cut-through fill to full with downstream stalled, then drain in order.
        delivered = 0;
        for (int k = 0; k < 5; k++) begin
            set_beat(4'(k), 32'hD000_0000 + 32'(k), 4'(k + 1), 1'b0, 2'(k));
            @(negedge clk);
            check("t2_level", 64'(o_level), 64'(k < 4 ? k : 4));
            check("t2_afull", 64'(o_af), 64'(k >= 3));
            check("t2_rready", 64'(o_mready), 64'(k < 4));
            if (k == 4) begin
                check("t2_svalid", 64'(o_svalid), 64'd1);
                check("t2_head", 64'(o_data), 64'hD000_0000);
            end
            cyc();
        end
        s_ready = 1'b1;
        send(4'd4, 32'hD000_0004, 4'd5, 1'b0, 2'd0);
        drain();
        check("t2_count", 64'(delivered), 64'd5);
        s_ready = 1'b0;

        // 5: simultaneous push/pop of RLAST beats at level 2.
        send(4'h5, 32'h5500_0000, 4'h5, 1'b1, 2'b00);
        send(4'h6, 32'h5500_0001, 4'h6, 1'b1, 2'b10);
        @(negedge clk);
        check("t5_level_pre", 64'(o_level), 64'd2);
        check("t5_bursts_pre", 64'(o_bursts), 64'd2);
        cyc();
        set_beat(4'h7, 32'h5500_0002, 4'h7, 1'b1, 2'b11);
        s_ready = 1'b1;
        @(negedge clk);
        check("t5_both", 64'({o_mready, o_svalid, o_last}), 64'b111);
        cyc();
        m_valid = 1'b0;
        s_ready = 1'b0;
        @(negedge clk);
        check("t5_level", 64'(o_level), 64'd2);
        check("t5_bursts", 64'(o_bursts), 64'd2);
        cyc();
        s_ready = 1'b1;
        drain();
        check("t5_bursts_end", 64'(o_bursts), 64'd0);

        // 3: store-and-forward holds a 3-beat burst until RLAST is buffered.
        do_reset(1'b1);
        s_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            set_beat(4'h2, 32'h3300_0000 + 32'(k), 4'h3, k == 2, 2'b00);
            @(negedge clk);
            check("t3_hold", 64'(o_svalid), 64'd0);
            cyc();
        end
        m_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("t3_valid", 64'(o_svalid), 64'd1);
            check("t3_id", 64'(o_id), 64'd2);
            check("t3_data", 64'(o_data), 64'h3300_0000 + 64'(k));
            check("t3_level", 64'(o_level), 64'(3 - k));
            check("t3_bursts", 64'(o_bursts), 64'd1);
            cyc();
        end
        @(negedge clk);
        check("t3_bursts_end", 64'(o_bursts), 64'd0);
        check("t3_empty", 64'(o_svalid), 64'd0);
        cyc();

        // 4: 6-beat burst longer than DEPTH forces the cut-through fallback.
        s_ready = 1'b0;
        ovf_cnt = 0;
        delivered = 0;
        for (int k = 0; k < 4; k++) send(4'h9, 32'h4400_0000 + 32'(k), 4'h9, 1'b0, 2'b00);
        set_beat(4'h9, 32'h4400_0004, 4'h9, 1'b0, 2'b00);
        @(negedge clk);
        check("t4_level", 64'(o_level), 64'd4);
        check("t4_ovf", 64'(o_ovf), 64'd1);
        check("t4_svalid", 64'(o_svalid), 64'd1);
        cyc();
        @(negedge clk);
        check("t4_ovf_pulse", 64'(o_ovf), 64'd0);
        check("t4_svalid2", 64'(o_svalid), 64'd1);
        cyc();
        s_ready = 1'b1;
        send(4'h9, 32'h4400_0004, 4'h9, 1'b0, 2'b00);
        send(4'h9, 32'h4400_0005, 4'h9, 1'b1, 2'b00);
        drain();
        check("t4_count", 64'(delivered), 64'd6);
        check("t4_ovf_cnt", 64'(ovf_cnt), 64'd1);
        // Back in HOLD: a lone non-last beat must not be released.
        send(4'hA, 32'h4400_0010, 4'hA, 1'b0, 2'b00);
        @(negedge clk);
        check("t4_hold_again", 64'(o_svalid), 64'd0);
        check("t4_hold_level", 64'(o_level), 64'd1);
        cyc();
        send(4'hA, 32'h4400_0011, 4'hA, 1'b1, 2'b00);
        drain();
        s_ready = 1'b0;

        // 6: random backpressure on both modes.
        random_run(4000);
        do_reset(1'b0);
        random_run(4000);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
